// File: rtl/issue_unit.sv
// In-order issue/rename stage: decodes the queue head, renames sources through the RAT,
// allocates a ROB entry and dispatches to the RS or LSB in the same cycle.
module issue_unit #(
    parameter int          ROB_IDX_W = 3,
    parameter logic [31:0] HALT_INST = 32'h0ff00513
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 iq_empty,
    input  logic [31:0]          iq_inst,
    input  logic [31:0]          iq_pc,
    input  logic                 iq_pred_taken,
    input  logic [31:0]          iq_pred_target,
    output logic                 iq_re,
    input  logic                 rob_full,
    input  logic                 rs_full,
    input  logic                 lsb_full,
    input  logic [ROB_IDX_W-1:0] rob_tail_tag,
    output logic                 rob_alloc,
    output logic [4:0]           rob_rd,
    output logic [31:0]          rob_pc,
    output logic                 rob_pred_taken,
    output logic [31:0]          rob_pred_target,
    output logic                 rob_ready_o,
    output logic                 rob_halt,
    output logic                 rs_we,
    output logic                 lsb_we,
    output logic [6:0]           disp_opcode,
    output logic [2:0]           disp_funct3,
    output logic                 disp_funct7b5,
    output logic [31:0]          disp_imm,
    output logic [31:0]          disp_pc,
    output logic [ROB_IDX_W-1:0] disp_dest,
    output logic [31:0]          disp_vj,
    output logic [31:0]          disp_vk,
    output logic [ROB_IDX_W-1:0] disp_qj,
    output logic [ROB_IDX_W-1:0] disp_qk,
    output logic                 disp_rj_ready,
    output logic                 disp_rk_ready,
    output logic [4:0]           rf_raddr1,
    output logic [4:0]           rf_raddr2,
    input  logic [31:0]          rf_rdata1,
    input  logic [31:0]          rf_rdata2,
    output logic [ROB_IDX_W-1:0] rob_qtag1,
    output logic [ROB_IDX_W-1:0] rob_qtag2,
    input  logic                 rob_qready1,
    input  logic                 rob_qready2,
    input  logic [31:0]          rob_qvalue1,
    input  logic [31:0]          rob_qvalue2,
    input  logic                 cdb_valid,
    input  logic [ROB_IDX_W-1:0] cdb_tag,
    input  logic [31:0]          cdb_value,
    input  logic                 commit_valid,
    input  logic [4:0]           commit_rd,
    input  logic [ROB_IDX_W-1:0] commit_tag
);
    typedef enum logic {RUN, HALTED} state_t;
    typedef struct packed {
        logic                 rdy;
        logic [ROB_IDX_W-1:0] q;
        logic [31:0]          v;
    } opnd_t;

    state_t                     state_q;
    logic [31:0]                rat_busy_q, rat_busy_d;
    logic [31:0][ROB_IDX_W-1:0] rat_tag_q, rat_tag_d;

    logic [6:0] opc;
    logic [4:0] rd, rs1, rs2, rd_eff;
    logic       is_load, is_store, is_lui, is_auipc, is_jal, is_jalr, is_br, is_opimm, is_op;
    logic       is_halt, to_lsb, to_rs, rob_only, unit_full, issue;
    opnd_t      op1, op2;

    // Resolve one source in priority order: x0, architectural file, ROB result, CDB, wait.
    function automatic opnd_t resolve(input logic used, input logic [4:0] r,
                                      input logic busy, input logic [ROB_IDX_W-1:0] tag,
                                      input logic [31:0] rf, input logic qrdy,
                                      input logic [31:0] qval, input logic cv,
                                      input logic [ROB_IDX_W-1:0] ct, input logic [31:0] cval);
        opnd_t o;
        o = '{rdy: 1'b1, q: '0, v: 32'd0};
        if (!used || r == 5'd0) o.v = 32'd0;
        else if (!busy)         o.v = rf;
        else if (qrdy)          o.v = qval;
        else if (cv && ct == tag) o.v = cval;
        else begin
            o.rdy = 1'b0;
            o.q   = tag;
        end
        return o;
    endfunction

    assign opc = iq_inst[6:0];
    assign rd  = iq_inst[11:7];
    assign rs1 = iq_inst[19:15];
    assign rs2 = iq_inst[24:20];

    // HALT_INST shares the OP-IMM opcode, so it must be excluded before unit selection.
    assign is_halt  = (iq_inst == HALT_INST);
    assign is_load  = (opc == 7'b0000011) && !is_halt;
    assign is_store = (opc == 7'b0100011) && !is_halt;
    assign is_lui   = (opc == 7'b0110111) && !is_halt;
    assign is_auipc = (opc == 7'b0010111) && !is_halt;
    assign is_jal   = (opc == 7'b1101111) && !is_halt;
    assign is_jalr  = (opc == 7'b1100111) && !is_halt;
    assign is_br    = (opc == 7'b1100011) && !is_halt;
    assign is_opimm = (opc == 7'b0010011) && !is_halt;
    assign is_op    = (opc == 7'b0110011) && !is_halt;

    assign to_lsb    = is_load || is_store;
    assign to_rs     = is_lui || is_auipc || is_jal || is_jalr || is_br || is_opimm || is_op;
    assign rob_only  = !to_lsb && !to_rs;
    assign unit_full = (to_lsb && lsb_full) || (to_rs && rs_full);
    assign issue     = (state_q == RUN) && !iq_empty && !flush && !rob_full && !unit_full;
    assign rd_eff    = (is_store || is_br || rob_only) ? 5'd0 : rd;

    always_comb begin
        disp_imm = 32'd0;
        if (is_load || is_opimm || is_jalr)
            disp_imm = {{20{iq_inst[31]}}, iq_inst[31:20]};
        else if (is_store)
            disp_imm = {{20{iq_inst[31]}}, iq_inst[31:25], iq_inst[11:7]};
        else if (is_br)
            disp_imm = {{19{iq_inst[31]}}, iq_inst[31], iq_inst[7], iq_inst[30:25],
                        iq_inst[11:8], 1'b0};
        else if (is_jal)
            disp_imm = {{11{iq_inst[31]}}, iq_inst[31], iq_inst[19:12], iq_inst[20],
                        iq_inst[30:21], 1'b0};
        else if (is_lui || is_auipc)
            disp_imm = {iq_inst[31:12], 12'd0};
    end

    assign rf_raddr1 = rs1;
    assign rf_raddr2 = rs2;
    assign rob_qtag1 = rat_tag_q[rs1];
    assign rob_qtag2 = rat_tag_q[rs2];

    assign op1 = resolve(!rob_only && !is_lui && !is_auipc && !is_jal, rs1, rat_busy_q[rs1],
                         rat_tag_q[rs1], rf_rdata1, rob_qready1, rob_qvalue1,
                         cdb_valid, cdb_tag, cdb_value);
    assign op2 = resolve(is_op || is_br || is_store, rs2, rat_busy_q[rs2],
                         rat_tag_q[rs2], rf_rdata2, rob_qready2, rob_qvalue2,
                         cdb_valid, cdb_tag, cdb_value);

    assign iq_re           = issue;
    assign rob_alloc       = issue;
    assign rs_we           = issue && to_rs;
    assign lsb_we          = issue && to_lsb;
    assign rob_rd          = rd_eff;
    assign rob_pc          = iq_pc;
    assign rob_pred_taken  = iq_pred_taken;
    assign rob_pred_target = iq_pred_target;
    assign rob_ready_o     = rob_only;
    assign rob_halt        = is_halt;
    assign disp_opcode     = opc;
    assign disp_funct3     = iq_inst[14:12];
    assign disp_funct7b5   = iq_inst[30];
    assign disp_pc         = iq_pc;
    assign disp_dest       = rob_tail_tag;
    assign disp_vj         = op1.v;
    assign disp_qj         = op1.q;
    assign disp_rj_ready   = op1.rdy;
    assign disp_vk         = op2.v;
    assign disp_qk         = op2.q;
    assign disp_rk_ready   = op2.rdy;

    // Issue is applied after commit so a same-cycle rename of the same rd wins.
    always_comb begin
        rat_busy_d = rat_busy_q;
        rat_tag_d  = rat_tag_q;
        if (flush) begin
            rat_busy_d = '0;
        end else begin
            if (commit_valid && commit_rd != 5'd0 && rat_busy_q[commit_rd] &&
                rat_tag_q[commit_rd] == commit_tag)
                rat_busy_d[commit_rd] = 1'b0;
            if (issue && rd_eff != 5'd0) begin
                rat_busy_d[rd_eff] = 1'b1;
                rat_tag_d[rd_eff]  = rob_tail_tag;
            end
        end
    end

    always_ff @(posedge clk) begin
        rat_tag_q <= rat_tag_d;
        if (rst) begin
            rat_busy_q <= '0;
            state_q    <= RUN;
        end else begin
            rat_busy_q <= rat_busy_d;
            if (issue && is_halt) state_q <= HALTED;
        end
    end
endmodule

// File: tb/tb_issue_unit.sv
// Self-checking bench for issue_unit: a sequential table of per-cycle vectors,
// each pushed to a scoreboard when driven and compared when sampled on the falling edge.
module tb_issue_unit;
    localparam int W = 3;

    logic          clk = 1'b0;
    logic          rst, flush, iq_empty, iq_pred_taken;
    logic [31:0]   iq_inst, iq_pc, iq_pred_target;
    logic          iq_re, rob_full, rs_full, lsb_full, rob_alloc;
    logic [W-1:0]  rob_tail_tag;
    logic [4:0]    rob_rd;
    logic [31:0]   rob_pc, rob_pred_target;
    logic          rob_pred_taken, rob_ready_o, rob_halt, rs_we, lsb_we;
    logic [6:0]    disp_opcode;
    logic [2:0]    disp_funct3;
    logic          disp_funct7b5;
    logic [31:0]   disp_imm, disp_pc, disp_vj, disp_vk;
    logic [W-1:0]  disp_dest, disp_qj, disp_qk;
    logic          disp_rj_ready, disp_rk_ready;
    logic [4:0]    rf_raddr1, rf_raddr2;
    logic [31:0]   rf_rdata1, rf_rdata2;
    logic [W-1:0]  rob_qtag1, rob_qtag2;
    logic          rob_qready1, rob_qready2;
    logic [31:0]   rob_qvalue1, rob_qvalue2;
    logic          cdb_valid;
    logic [W-1:0]  cdb_tag;
    logic [31:0]   cdb_value;
    logic          commit_valid;
    logic [4:0]    commit_rd;
    logic [W-1:0]  commit_tag;

    issue_unit #(.ROB_IDX_W(W), .HALT_INST(32'h0ff00513)) dut (
        .clk(clk), .rst(rst), .flush(flush), .iq_empty(iq_empty), .iq_inst(iq_inst),
        .iq_pc(iq_pc), .iq_pred_taken(iq_pred_taken), .iq_pred_target(iq_pred_target),
        .iq_re(iq_re), .rob_full(rob_full), .rs_full(rs_full), .lsb_full(lsb_full),
        .rob_tail_tag(rob_tail_tag), .rob_alloc(rob_alloc), .rob_rd(rob_rd), .rob_pc(rob_pc),
        .rob_pred_taken(rob_pred_taken), .rob_pred_target(rob_pred_target),
        .rob_ready_o(rob_ready_o), .rob_halt(rob_halt), .rs_we(rs_we), .lsb_we(lsb_we),
        .disp_opcode(disp_opcode), .disp_funct3(disp_funct3), .disp_funct7b5(disp_funct7b5),
        .disp_imm(disp_imm), .disp_pc(disp_pc), .disp_dest(disp_dest),
        .disp_vj(disp_vj), .disp_vk(disp_vk), .disp_qj(disp_qj), .disp_qk(disp_qk),
        .disp_rj_ready(disp_rj_ready), .disp_rk_ready(disp_rk_ready),
        .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_rdata1(rf_rdata1),
        .rf_rdata2(rf_rdata2), .rob_qtag1(rob_qtag1), .rob_qtag2(rob_qtag2),
        .rob_qready1(rob_qready1), .rob_qready2(rob_qready2), .rob_qvalue1(rob_qvalue1),
        .rob_qvalue2(rob_qvalue2), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
        .cdb_value(cdb_value), .commit_valid(commit_valid), .commit_rd(commit_rd),
        .commit_tag(commit_tag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] inst;
        logic        empty, flush, rob_full, rs_full, lsb_full;
        logic [W-1:0] tail;
        logic        qr1, qr2;
        logic [31:0] qv1, qv2;
        logic        cv;
        logic [W-1:0] ct;
        logic [31:0] cval;
        logic        cmv;
        logic [4:0]  cmrd;
        logic [W-1:0] cmtag;
        logic [3:0]  str;   // {iq_re, rob_alloc, rs_we, lsb_we}
        logic [4:0]  rd;
        logic [31:0] imm;
        logic        rj;
        logic [31:0] vj;
        logic [W-1:0] qj;
        logic        rk;
        logic [31:0] vk;
        logic [W-1:0] qk;
        logic        rdy, halt;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];
    int   n_pass = 0, n_total = 0, row = 0;

    function automatic vec_t mk(logic [31:0] inst, logic [W-1:0] tail, logic [3:0] str,
                                logic [4:0] rd, logic [31:0] imm,
                                logic rj, logic [31:0] vj, logic [W-1:0] qj,
                                logic rk, logic [31:0] vk, logic [W-1:0] qk);
        vec_t v;
        v = '{inst: inst, empty: 1'b0, flush: 1'b0, rob_full: 1'b0, rs_full: 1'b0,
              lsb_full: 1'b0, tail: tail, qr1: 1'b0, qr2: 1'b0, qv1: 32'd0, qv2: 32'd0,
              cv: 1'b0, ct: '0, cval: 32'd0, cmv: 1'b0, cmrd: 5'd0, cmtag: '0,
              str: str, rd: rd, imm: imm, rj: rj, vj: vj, qj: qj, rk: rk, vk: vk, qk: qk,
              rdy: 1'b0, halt: 1'b0};
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
    endtask

    task automatic apply(input vec_t v);
        iq_inst = v.inst; iq_empty = v.empty; flush = v.flush; rob_full = v.rob_full;
        rs_full = v.rs_full; lsb_full = v.lsb_full; rob_tail_tag = v.tail;
        rob_qready1 = v.qr1; rob_qready2 = v.qr2; rob_qvalue1 = v.qv1; rob_qvalue2 = v.qv2;
        cdb_valid = v.cv; cdb_tag = v.ct; cdb_value = v.cval;
        commit_valid = v.cmv; commit_rd = v.cmrd; commit_tag = v.cmtag;
        iq_pc = 32'h1000 + 32'(row * 4);
    endtask

    task automatic run_row(input vec_t v);
        vec_t e;
        @(posedge clk);
        #1;
        apply(v);
        exp_q.push_back(v);
        @(negedge clk);
        e = exp_q.pop_front();
        chk("strobes", {28'd0, iq_re, rob_alloc, rs_we, lsb_we}, {28'd0, e.str});
        if (e.str[3]) begin
            chk("rob_rd", {27'd0, rob_rd}, {27'd0, e.rd});
            chk("rob_flags", {30'd0, rob_ready_o, rob_halt}, {30'd0, e.rdy, e.halt});
            chk("disp_dest", 32'(disp_dest), 32'(e.tail));
            chk("rob_pc", rob_pc, 32'h1000 + 32'(row * 4));
        end
        if (e.str[1] || e.str[0]) begin
            chk("disp_imm", disp_imm, e.imm);
            chk("rj_ready", {31'd0, disp_rj_ready}, {31'd0, e.rj});
            if (e.rj) chk("vj", disp_vj, e.vj); else chk("qj", 32'(disp_qj), 32'(e.qj));
            chk("rk_ready", {31'd0, disp_rk_ready}, {31'd0, e.rk});
            if (e.rk) chk("vk", disp_vk, e.vk); else chk("qk", 32'(disp_qk), 32'(e.qk));
        end
        row++;
    endtask

    localparam logic [31:0] ADDI_X1  = 32'h00500093;
    localparam logic [31:0] ADD_2_11 = 32'h00108133;
    localparam logic [31:0] ADD_3_12 = 32'h002081B3;
    localparam logic [31:0] ADD_4_11 = 32'h00108233;
    localparam logic [31:0] LW_5_4   = 32'h00822283;
    localparam logic [31:0] SW_5_3   = 32'hFE51AE23;
    localparam logic [31:0] ADD_6_10 = 32'h00008333;
    localparam logic [31:0] ADD_7_32 = 32'h002183B3;
    localparam logic [31:0] LUI_X8   = 32'h12345437;
    localparam logic [31:0] JAL_X1   = 32'hFF9FF0EF;
    localparam logic [31:0] BEQ_1_2  = 32'h00208863;
    localparam logic [31:0] UNKNOWN  = 32'h00000FFF;
    localparam logic [31:0] HALT     = 32'h0ff00513;

    initial begin
        vec_t v;
        rst = 1'b1; flush = 1'b0; iq_empty = 1'b1; iq_inst = 32'd0; iq_pc = 32'd0;
        iq_pred_taken = 1'b0; iq_pred_target = 32'h2000; rob_full = 1'b0; rs_full = 1'b0;
        lsb_full = 1'b0; rob_tail_tag = '0; rob_qready1 = 1'b0; rob_qready2 = 1'b0;
        rob_qvalue1 = 32'd0; rob_qvalue2 = 32'd0; cdb_valid = 1'b0; cdb_tag = '0;
        cdb_value = 32'd0; commit_valid = 1'b0; commit_rd = 5'd0; commit_tag = '0;
        rf_rdata1 = 32'h11; rf_rdata2 = 32'h22;

        v = mk(ADDI_X1, 0, 4'b0000, 0, 0, 1, 0, 0, 1, 0, 0); v.empty = 1'b1; tbl.push_back(v);
        tbl.push_back(mk(ADDI_X1, 2, 4'b1110, 1, 5, 1, 0, 0, 1, 0, 0));
        tbl.push_back(mk(ADD_2_11, 3, 4'b1110, 2, 0, 0, 0, 2, 0, 0, 2));
        v = mk(ADD_2_11, 4, 4'b1110, 2, 0, 1, 5, 0, 1, 5, 0);
        v.cv = 1'b1; v.ct = 2; v.cval = 5; tbl.push_back(v);
        v = mk(ADD_3_12, 5, 4'b1110, 3, 0, 1, 32'h77, 0, 1, 32'h99, 0);
        v.qr1 = 1'b1; v.qv1 = 32'h77; v.cv = 1'b1; v.ct = 4; v.cval = 32'h99; tbl.push_back(v);
        v = mk(ADD_4_11, 6, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0); v.rs_full = 1'b1; tbl.push_back(v);
        v = mk(LW_5_4, 6, 4'b1101, 5, 8, 1, 32'h11, 0, 1, 0, 0); v.rs_full = 1'b1; tbl.push_back(v);
        v = mk(LW_5_4, 7, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0); v.lsb_full = 1'b1; tbl.push_back(v);
        tbl.push_back(mk(SW_5_3, 7, 4'b1101, 0, 32'hFFFFFFFC, 0, 0, 5, 0, 0, 6));
        v = mk(ADDI_X1, 3, 4'b1110, 1, 5, 1, 0, 0, 1, 0, 0);
        v.cmv = 1'b1; v.cmrd = 1; v.cmtag = 2; tbl.push_back(v);
        v = mk(ADDI_X1, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0);
        v.empty = 1'b1; v.cmv = 1'b1; v.cmrd = 1; v.cmtag = 2; tbl.push_back(v);
        tbl.push_back(mk(ADD_6_10, 0, 4'b1110, 6, 0, 0, 0, 3, 1, 0, 0));
        v = mk(ADDI_X1, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0);
        v.empty = 1'b1; v.cmv = 1'b1; v.cmrd = 1; v.cmtag = 3; tbl.push_back(v);
        tbl.push_back(mk(ADD_6_10, 1, 4'b1110, 6, 0, 1, 32'h11, 0, 1, 0, 0));
        v = mk(ADD_7_32, 2, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0); v.flush = 1'b1; tbl.push_back(v);
        tbl.push_back(mk(ADD_7_32, 2, 4'b1110, 7, 0, 1, 32'h11, 0, 1, 32'h22, 0));
        v = mk(ADDI_X1, 3, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0); v.rob_full = 1'b1; tbl.push_back(v);
        tbl.push_back(mk(LUI_X8, 3, 4'b1110, 8, 32'h12345000, 1, 0, 0, 1, 0, 0));
        tbl.push_back(mk(JAL_X1, 4, 4'b1110, 1, 32'hFFFFFFF8, 1, 0, 0, 1, 0, 0));
        tbl.push_back(mk(BEQ_1_2, 5, 4'b1110, 0, 32'd16, 0, 0, 4, 1, 32'h22, 0));
        v = mk(UNKNOWN, 6, 4'b1100, 0, 0, 0, 0, 0, 0, 0, 0); v.rdy = 1'b1; tbl.push_back(v);
        v = mk(HALT, 7, 4'b1100, 0, 0, 0, 0, 0, 0, 0, 0); v.rdy = 1'b1; v.halt = 1'b1;
        tbl.push_back(v);
        tbl.push_back(mk(ADDI_X1, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0));
        v = mk(ADDI_X1, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0); v.flush = 1'b1; tbl.push_back(v);
        tbl.push_back(mk(ADDI_X1, 1, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0));

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        foreach (tbl[i]) run_row(tbl[i]);

        // Only reset leaves the halted state.
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        run_row(mk(ADDI_X1, 2, 4'b1110, 1, 5, 1, 0, 0, 1, 0, 0));
        run_row(mk(ADD_2_11, 3, 4'b1110, 2, 0, 0, 0, 2, 0, 0, 2));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout row %0d: got no finish expected finish", row);
        $fatal(1, "timeout");
    end
endmodule
